req_encoder_4to2: RTL and testbench
===================================

Name: req_encoder_4to2

Overview:
- Sequential 4-to-2 encoder. It accepts a 4-bit request word d[3:0] over a valid/ready handshake.
- It emits the 2-bit index of every set bit, one index per output handshake, in priority order. It flags the final index with b_last.
- It is the inverse partner of the team's 2-to-4 line decoder. It sits between request-line sources and index-consuming logic, such as an arbiter or a decoder-driven select.

Parameters:
- LOW_FIRST, 1: 1 = emit indices lowest bit first (d[0] before d[3]); 0 = highest bit first.
- N_IN, 4: input width. Fixed at 4 in this revision; any other value is a synthesis error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- d_valid  in  1  request word present
- d_ready  out  1  block can accept a word
- d  in  4  request lines d[3:0]
- b_valid  out  1  index present on b
- b_ready  in  1  consumer takes the index
- b  out  2  encoded index {b1,b0} of the selected set bit
- b_last  out  1  b is the final index of the current word
- zero_err  out  1  one-cycle pulse: an all-zero word was accepted

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- While rst_n=0, the following are all 0 immediately, independent of clk: state=IDLE, pend=0, d_ready, b_valid, b, b_last, zero_err.
- State machine, states IDLE and EMIT:
  - d_ready is a registered output. It goes to 1 on the first clk edge after rst_n rises.
  - d_ready is 1 only in IDLE.
- IDLE, on d_valid && d_ready at edge k:
  - If d != 0: pend <= d, state <= EMIT, d_ready <= 0.
  - If d == 0: zero_err=1 for cycle k+1 only. Stay in IDLE with d_ready=1. No b_valid.
- EMIT outputs, all derived from registers:
  - b_valid=1.
  - b = index of the lowest set bit of pend (LOW_FIRST=1) or the highest set bit (LOW_FIRST=0).
  - b_last = 1 when pend has exactly one set bit.
  - First index is valid in cycle k+1 (latency 1).
- EMIT, on b_valid && b_ready at an edge:
  - Clear the emitted bit in pend.
  - If b_last: state <= IDLE, d_ready <= 1, b_valid <= 0. A new word can be accepted at the following edge, so there is one bubble cycle.
  - Otherwise stay in EMIT. The next index appears in the next cycle, giving throughput of 1 index/cycle while b_ready=1.
- Backpressure: while b_valid && !b_ready, b and b_last hold stable and pend is unchanged.
- Data: d is ignored outside an accepting edge. d_valid while d_ready=0 has no effect; the source must hold it.
- Index mapping: b=00 for d[0], 01 for d[1], 10 for d[2], 11 for d[3].
- Reset mid-EMIT: the pending word is discarded and the outputs clear asynchronously. No partial-word state survives.

Decomposition:
- Shared package:
  - state enum {IDLE, EMIT}
  - constant N_IN=4 and index width 2
  - function onehot_count (popcount for b_last)
- One combinational sub-module, prio_enc4: inputs d[3:0] and dir; outputs idx[1:0] and any.
  - Instantiated once on pend.
  - Reusable wherever the team needs a bare priority encoder.

Test Plan:
- Reset: hold rst_n=0 with d_valid=1, d=4'b1111 -> all outputs 0; after release, d_ready=0 at the first edge and 1 from the second edge; nothing accepted during reset.
- Multi-bit word, LOW_FIRST=1, b_ready=1: d=4'b1010 -> b=01 with b_last=0, next cycle b=11 with b_last=1, then b_valid=0 and d_ready=1 the following cycle.
- Backpressure: d=4'b0100, b_ready=0 for 3 cycles -> b=10, b_last=1, b_valid=1 stable all 3 cycles; completes on the cycle b_ready=1.
- Zero word: d=4'b0000 accepted -> zero_err=1 for exactly one cycle, b_valid stays 0, d_ready stays 1, and the next word d=4'b0001 gives b=00 with b_last=1.
- Descending order, LOW_FIRST=0: d=4'b1111, b_ready=1 -> b sequence 11,10,01,00 on 4 consecutive cycles, b_last only on 00.
- Reset mid-operation: d=4'b1111, assert rst_n=0 after the first index -> b_valid, b and d_ready drop immediately; after release, d=4'b1000 yields a single b=11 with b_last=1 and no stale indices.

Source files
------------

// File: rtl/req_encoder_4to2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : req_encoder_4to2_pkg
// Purpose  : Shared types, constants and helpers for the sequential 4-to-2
//            request encoder and its priority-encoder building block.
// Revision : 1.0  initial release
// ============================================================================
package req_encoder_4to2_pkg;

  // Width of the request word and of the encoded index
  localparam int unsigned c_N_IN  = 4;
  localparam int unsigned c_IDX_W = 2;

  // Two-state controller: waiting for a word, or streaming its indices out
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Number of set bits in a request word; a count of one marks the last index
  function automatic logic [2:0] onehot_count(input logic [c_N_IN-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < int'(c_N_IN); i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage : req_encoder_4to2_pkg
`default_nettype wire

// File: rtl/req_encoder_4to2_prio_enc4.sv
`default_nettype none
// ============================================================================
// Module   : prio_enc4
// Purpose  : Bare combinational 4-input priority encoder. dir=1 selects the
//            lowest set bit, dir=0 the highest. any flags a non-zero input;
//            idx is 0 when no bit is set.
// Revision : 1.0  initial release
// ============================================================================
module prio_enc4
  import req_encoder_4to2_pkg::*;
(
  input  logic [c_N_IN-1:0]  d,
  input  logic               dir,
  output logic [c_IDX_W-1:0] idx,
  output logic               any
);

  // Scan so that the winning bit is the last one assigned in the loop
  always_comb begin
    idx = '0;
    any = |d;
    if (dir) begin
      for (int i = int'(c_N_IN) - 1; i >= 0; i--) begin
        if (d[i]) idx = c_IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(c_N_IN); i++) begin
        if (d[i]) idx = c_IDX_W'(i);
      end
    end
  end

endmodule : prio_enc4
`default_nettype wire

// File: rtl/req_encoder_4to2.sv
`default_nettype none
// ============================================================================
// Module   : req_encoder_4to2
// Purpose  : Sequential 4-to-2 encoder. Accepts a request word over a
//            valid/ready handshake and emits the index of every set bit,
//            one per output handshake, in priority order, marking the final
//            index with b_last. An all-zero word produces a zero_err pulse.
// Revision : 1.0  initial release
// ============================================================================
module req_encoder_4to2
  import req_encoder_4to2_pkg::*;
#(
  parameter bit          LOW_FIRST = 1'b1,
  parameter int unsigned N_IN      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d_valid,
  output logic               d_ready,
  input  logic [N_IN-1:0]    d,
  output logic               b_valid,
  input  logic               b_ready,
  output logic [c_IDX_W-1:0] b,
  output logic               b_last,
  output logic               zero_err
);

  // Only the 4-input form exists in this revision
  generate
    if (N_IN != c_N_IN) begin : g_bad_n_in
      $error("req_encoder_4to2: N_IN must be 4");
    end
  endgenerate

  state_t              r_state;
  logic [N_IN-1:0]     r_pend;
  logic                r_d_ready;
  logic                r_b_valid;
  logic                r_zero_err;

  logic [c_IDX_W-1:0]  w_idx;
  logic                w_any;
  logic                w_last;
  logic [N_IN-1:0]     w_clr_mask;

  // Selects the next index to emit from the still-pending bits
  prio_enc4 u_prio_enc4 (
    .d   (r_pend),
    .dir (LOW_FIRST),
    .idx (w_idx),
    .any (w_any)
  );

  assign w_last     = (onehot_count(r_pend) == 3'd1);
  assign w_clr_mask = {{(N_IN-1){1'b0}}, 1'b1} << w_idx;

  // Controller: accept a word in IDLE, stream its indices in EMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_d_ready  <= 1'b0;
      r_b_valid  <= 1'b0;
      r_zero_err <= 1'b0;
    end else begin
      r_zero_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_d_ready <= 1'b1;
          if (d_valid && r_d_ready) begin
            if (d != '0) begin
              r_pend    <= d;
              r_state   <= EMIT;
              r_d_ready <= 1'b0;
              r_b_valid <= 1'b1;
            end else begin
              r_zero_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (r_b_valid && b_ready) begin
            r_pend <= r_pend & ~w_clr_mask;
            if (w_last) begin
              r_state   <= IDLE;
              r_d_ready <= 1'b1;
              r_b_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_pend    <= '0;
          r_d_ready <= 1'b0;
          r_b_valid <= 1'b0;
        end
      endcase
    end
  end

  // Index outputs come straight from the pending register, gated by valid
  assign d_ready  = r_d_ready;
  assign b_valid  = r_b_valid;
  assign b        = (r_b_valid && w_any) ? w_idx : '0;
  assign b_last   = r_b_valid && w_last;
  assign zero_err = r_zero_err;

endmodule : req_encoder_4to2
`default_nettype wire

// File: tb/tb_req_encoder_4to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_encoder_4to2
// Purpose  : Self-checking bench for req_encoder_4to2. Two instances (lowest
//            first and highest first) share one stimulus stream and are
//            compared every cycle against a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_req_encoder_4to2;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       d_valid = 1'b0;
  logic       b_ready = 1'b0;
  logic [3:0] d       = 4'h0;

  logic       d_ready_lo, b_valid_lo, b_last_lo, zero_err_lo;
  logic [1:0] b_lo;
  logic       d_ready_hi, b_valid_hi, b_last_hi, zero_err_hi;
  logic [1:0] b_hi;

  int checks   = 0;
  int failures = 0;

  // Reference model: queues of indices still to be emitted for each order
  int q_lo[$];
  int q_hi[$];
  bit m_ready;
  bit m_zero;

  req_encoder_4to2 #(.LOW_FIRST(1'b1), .N_IN(4)) u_dut_lo (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_valid  (d_valid),
    .d_ready  (d_ready_lo),
    .d        (d),
    .b_valid  (b_valid_lo),
    .b_ready  (b_ready),
    .b        (b_lo),
    .b_last   (b_last_lo),
    .zero_err (zero_err_lo)
  );

  req_encoder_4to2 #(.LOW_FIRST(1'b0), .N_IN(4)) u_dut_hi (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_valid  (d_valid),
    .d_ready  (d_ready_hi),
    .d        (d),
    .b_valid  (b_valid_hi),
    .b_ready  (b_ready),
    .b        (b_hi),
    .b_last   (b_last_hi),
    .zero_err (zero_err_hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] eb_lo, eb_hi;
    eb_lo = (q_lo.size() > 0) ? 2'(q_lo[0]) : 2'd0;
    eb_hi = (q_hi.size() > 0) ? 2'(q_hi[0]) : 2'd0;
    chk("lo.d_ready",  {1'b0, d_ready_lo},  {1'b0, m_ready});
    chk("lo.b_valid",  {1'b0, b_valid_lo},  {1'b0, q_lo.size() > 0});
    chk("lo.b",        b_lo,                eb_lo);
    chk("lo.b_last",   {1'b0, b_last_lo},   {1'b0, q_lo.size() == 1});
    chk("lo.zero_err", {1'b0, zero_err_lo}, {1'b0, m_zero});
    chk("hi.d_ready",  {1'b0, d_ready_hi},  {1'b0, m_ready});
    chk("hi.b_valid",  {1'b0, b_valid_hi},  {1'b0, q_hi.size() > 0});
    chk("hi.b",        b_hi,                eb_hi);
    chk("hi.b_last",   {1'b0, b_last_hi},   {1'b0, q_hi.size() == 1});
    chk("hi.zero_err", {1'b0, zero_err_hi}, {1'b0, m_zero});
  endtask

  task automatic model_reset();
    q_lo.delete();
    q_hi.delete();
    m_ready = 1'b0;
    m_zero  = 1'b0;
  endtask

  // Advance the model by one rising edge with the given sampled inputs
  task automatic model_edge(input bit dv, input logic [3:0] dd, input bit br);
    bit zero_next;
    zero_next = 1'b0;
    if (q_lo.size() > 0) begin
      if (br) begin
        void'(q_lo.pop_front());
        void'(q_hi.pop_front());
        if (q_lo.size() == 0) m_ready = 1'b1;
      end
    end else if (dv && m_ready) begin
      if (dd != 4'h0) begin
        for (int i = 0; i < 4; i++)  if (dd[i]) q_lo.push_back(i);
        for (int i = 3; i >= 0; i--) if (dd[i]) q_hi.push_back(i);
        m_ready = 1'b0;
      end else begin
        zero_next = 1'b1;
      end
    end else begin
      m_ready = 1'b1;
    end
    m_zero = zero_next;
  endtask

  // One cycle: check current outputs, drive new inputs, clock the model
  task automatic cycle(input bit dv, input logic [3:0] dd, input bit br);
    @(negedge clk);
    check_outputs();
    d_valid = dv;
    d       = dd;
    b_ready = br;
    @(posedge clk);
    model_edge(dv, dd, br);
  endtask

  initial begin
    // Reset held with a full request presented: nothing may be accepted
    rst_n   = 1'b0;
    d_valid = 1'b1;
    d       = 4'hF;
    b_ready = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
    #1 check_outputs();
    @(posedge clk);
    model_edge(1'b0, 4'h0, 1'b1);
    d_valid = 1'b0;

    // Multi-bit word with free-flowing consumer
    cycle(1'b1, 4'b1010, 1'b1);
    repeat (3) cycle(1'b0, 4'h0, 1'b1);

    // Backpressure on a single-bit word
    cycle(1'b1, 4'b0100, 1'b0);
    repeat (3) cycle(1'b0, 4'h0, 1'b0);
    repeat (2) cycle(1'b0, 4'h0, 1'b1);

    // Zero word, then a single-bit word
    cycle(1'b1, 4'b0000, 1'b1);
    cycle(1'b1, 4'b0001, 1'b1);
    repeat (3) cycle(1'b0, 4'h0, 1'b1);

    // All bits set: both orders stream four indices back to back
    cycle(1'b1, 4'b1111, 1'b1);
    repeat (5) cycle(1'b0, 4'h0, 1'b1);

    // Reset in the middle of a word, after the first index is taken
    cycle(1'b1, 4'b1111, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_outputs();
    @(posedge clk);
    model_edge(1'b0, 4'h0, 1'b1);
    cycle(1'b1, 4'b1000, 1'b1);
    repeat (3) cycle(1'b0, 4'h0, 1'b1);

    // Randomized traffic with random backpressure
    repeat (400) begin
      cycle(($urandom_range(0, 3) != 0), 4'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (6) cycle(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_req_encoder_4to2
`default_nettype wire
